nic_fifo: RTL and testbench
===========================

NIC_FIFO -- requirements
Module: nic_fifo

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 64, meaning the packet/data width in bits.
REQ-002 SHALL have parameter IN_DEPTH, default 4, meaning the input FIFO entries (power of 2, ≥2).
REQ-003 SHALL have parameter OUT_DEPTH, default 4, meaning the output FIFO entries (power of 2, ≥2).
REQ-004 SHALL have parameter TX_POLARITY, default 1, meaning the net_polarity value on which sends are permitted.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports listed clock first, then reset:
- clk  in  1  the single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have the remaining ports, one per line:
- addr  in  2  CPU register select.
- d_in  in  PACKET_WIDTH  CPU write data.
- d_out  out  PACKET_WIDTH  CPU read data, registered.
- nicEn  in  1  CPU access enable.
- nicEnWR  in  1  CPU write strobe (qualified by nicEn).
- net_si  in  1  router send, input channel.
- net_ri  out  1  ready, input channel.
- net_di  in  PACKET_WIDTH  router packet, input channel.
- net_so  out  1  send, output channel, registered.
- net_ro  in  1  router ready, output channel.
- net_do  out  PACKET_WIDTH  packet, output channel, registered.
- net_polarity  in  1  router polarity.

Function
REQ-007 SHALL track in_count (0..IN_DEPTH) and out_count (0..OUT_DEPTH), each $clog2(DEPTH)+1 bits wide, using wrap-around read/write pointers.
REQ-008 SHALL drive net_ri combinationally as (in_count != IN_DEPTH).
REQ-009 SHALL push net_di into the input FIFO on an edge where net_si && net_ri; net_si while net_ri=0 is ignored, with no state change.
REQ-010 SHALL, on an edge where out_count != 0 && net_ro && net_polarity == TX_POLARITY: register net_do <= head, set net_so <= 1, and pop the head.
- Otherwise net_so <= 0 and net_do holds.
- Back-to-back sends occur on consecutive cycles while the condition holds.
REQ-011 SHALL, for CPU write (nicEn && nicEnWR && addr==2'b10):
- push d_in if out_count != OUT_DEPTH;
- if full, drop the word and set sticky drop_flag.
REQ-012 SHALL ignore CPU writes to addr 00/01/11.
REQ-013 SHALL perform CPU reads (nicEn && !nicEnWR) with 1-cycle latency (d_out valid the edge after the request):
- addr 00: input head, and pop it if in_count != 0; return 0 with no pop if empty.
- addr 01: (in_count << 1) | (in_count != 0).
- addr 10: 0.
- addr 11: (out_count << 2) | (drop_flag << 1) | (out_count == OUT_DEPTH); this read clears drop_flag.
REQ-014 SHALL set d_out <= 0 on an edge where nicEn=0.
REQ-015 SHALL, on a simultaneous push and pop on the same FIFO in the same edge, leave the count unchanged and perform both.
REQ-016 SHALL evaluate fullness for REQ-011 on the registered out_count, so a CPU push to a full FIFO is dropped even if a network pop happens on the same edge.
REQ-017 SHALL treat the all-zero packet as valid data; emptiness is count-based only.

Reset
REQ-018 SHALL, while reset=0, asynchronously set:
- both counts and all pointers to 0, and drop_flag = 0;
- d_out = 0, net_so = 0, net_do = 0;
- net_ri = 1 (follows from in_count = 0).
REQ-019 SHALL not clear FIFO storage arrays on reset (contents are don't-care once counts are 0).
REQ-020 SHALL, on reset asserted mid-transfer, lose all in-flight data and restart from the empty state on the first edge after release.

Structure
REQ-021 SHALL place the following in shared package nic_pkg:
- address constants ADDR_IN_DATA=2'b00, ADDR_IN_STAT=2'b01, ADDR_OUT_DATA=2'b10, ADDR_OUT_STAT=2'b11;
- status bit positions (NONEMPTY/FULL=0, DROP=1, COUNT LSB).
REQ-022 SHALL implement both FIFOs as two instances of one sub-module nic_sync_fifo, parameters WIDTH and DEPTH, ports push, pop, wdata, rdata (head), count, full, empty.

Verification
REQ-023 SHALL verify that after reset with CPU writes 0xA1, 0xA2 to addr 10 and net_ro=1, net_polarity=1, net_so pulses on two consecutive cycles with net_do = 0xA1 then 0xA2, and addr 11 then reads 0.
REQ-024 SHALL verify that with net_polarity=0 (TX_POLARITY=1) and 4 words written, net_so stays 0 and addr 11 reads 0x11; after polarity is raised, 4 sends occur.
REQ-025 SHALL verify that when the router sends 4 words 0x1..0x4 with no CPU reads, net_ri falls after the 4th, a 5th net_si is ignored, addr 01 reads 0x9, and four addr 00 reads return 1, 2, 3, 4 then 0.
REQ-026 SHALL verify that a 5th CPU write while the output FIFO is full and net_ro=0 makes addr 11 read 0x13, a second read returns 0x11, and the dropped word is never sent.
REQ-027 SHALL verify that with the input FIFO full, an addr 00 read and net_si on the same edge leave in_count at 4 only if net_ri was 1; otherwise in_count drops to 3 and net_ri=1 next cycle.
REQ-028 SHALL verify that reset pulsed low mid-burst (2 words queued each side) makes net_so=0, d_out=0, and net_ri=1 immediately, and both status reads return 0 after release.

Source files
------------

// File: rtl/nic_pkg.sv
// nic_pkg: register map and status-word bit positions shared by the NIC FIFO blocks
package nic_pkg;
  localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;
  localparam int STAT_NONEMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT      = 0;
  localparam int STAT_DROP_BIT      = 1;
  localparam int STAT_IN_COUNT_LSB  = 1;
  localparam int STAT_OUT_COUNT_LSB = 2;
endpackage

// File: rtl/nic_sync_fifo.sv
// nic_sync_fifo: single-clock FIFO with count-based full/empty and a combinational head
module nic_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // Storage is deliberately left out of reset; empty counts make it don't-care.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/nic_fifo.sv
// nic_fifo: CPU-facing NIC with a router-fed input FIFO and a polarity-gated output FIFO
module nic_fifo
  import nic_pkg::*;
#(
  parameter int   PACKET_WIDTH = 64,
  parameter int   IN_DEPTH     = 4,
  parameter int   OUT_DEPTH    = 4,
  parameter logic TX_POLARITY  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              addr,
  input  logic [PACKET_WIDTH-1:0] d_in,
  output logic [PACKET_WIDTH-1:0] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  input  logic                    net_si,
  output logic                    net_ri,
  input  logic [PACKET_WIDTH-1:0] net_di,
  output logic                    net_so,
  input  logic                    net_ro,
  output logic [PACKET_WIDTH-1:0] net_do,
  input  logic                    net_polarity
);
  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;
  logic [ICW-1:0] in_count;
  logic [OCW-1:0] out_count;
  logic [PACKET_WIDTH-1:0] in_head, out_head, in_stat, out_stat, rd_data;
  logic in_full, in_empty, out_full, out_empty;
  logic cpu_rd, cpu_wr, in_push, in_pop, out_push, out_pop, drop_set, drop_clr, drop_flag;
  assign cpu_rd   = nicEn && !nicEnWR;
  assign cpu_wr   = nicEn && nicEnWR;
  assign net_ri   = !in_full;
  assign in_push  = net_si && net_ri;
  assign in_pop   = cpu_rd && addr == ADDR_IN_DATA && !in_empty;
  assign out_pop  = !out_empty && net_ro && net_polarity == TX_POLARITY;
  // Fullness is the registered count, so a same-edge network pop cannot rescue a write.
  assign out_push = cpu_wr && addr == ADDR_OUT_DATA && !out_full;
  assign drop_set = cpu_wr && addr == ADDR_OUT_DATA && out_full;
  assign drop_clr = cpu_rd && addr == ADDR_OUT_STAT;
  always_comb begin
    in_stat = PACKET_WIDTH'(in_count) << STAT_IN_COUNT_LSB;
    in_stat[STAT_NONEMPTY_BIT] = !in_empty;
    out_stat = PACKET_WIDTH'(out_count) << STAT_OUT_COUNT_LSB;
    out_stat[STAT_DROP_BIT] = drop_flag;
    out_stat[STAT_FULL_BIT] = out_full;
    rd_data = addr == ADDR_IN_DATA  ? (in_empty ? '0 : in_head) :
              addr == ADDR_IN_STAT  ? in_stat :
              addr == ADDR_OUT_STAT ? out_stat : '0;
  end
  nic_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(IN_DEPTH)) u_in (
    .clk(clk), .reset(reset), .push(in_push), .pop(in_pop), .wdata(net_di),
    .rdata(in_head), .count(in_count), .full(in_full), .empty(in_empty)
  );
  nic_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(OUT_DEPTH)) u_out (
    .clk(clk), .reset(reset), .push(out_push), .pop(out_pop), .wdata(d_in),
    .rdata(out_head), .count(out_count), .full(out_full), .empty(out_empty)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out     <= '0;
      net_so    <= 1'b0;
      net_do    <= '0;
      drop_flag <= 1'b0;
    end else begin
      d_out     <= !nicEn ? '0 : cpu_rd ? rd_data : d_out;
      net_so    <= out_pop;
      net_do    <= out_pop ? out_head : net_do;
      drop_flag <= drop_set || (drop_flag && !drop_clr);
    end
  end
endmodule

// File: tb/tb_nic_fifo.sv
// tb_nic_fifo: directed scoreboard bench for nic_fifo CPU, router and reset behaviour
module tb_nic_fifo;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] addr;
  logic [63:0] d_in, d_out, net_di, net_do;
  logic nicEn, nicEnWR, net_si, net_ri, net_so, net_ro, net_polarity;
  logic [63:0] tx_q[$];
  logic [63:0] rd_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_sent = 0;
  int sent0;

  nic_fifo dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicEnWR(nicEnWR), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every observed send must match the oldest word the bench expects to leave.
  always @(negedge clk) begin
    if (net_so === 1'b1) begin
      if (tx_q.size() == 0) check("tx_unexpected_so", {63'b0, net_so}, 64'd0);
      else check("tx_data", net_do, tx_q.pop_front());
      n_sent++;
    end
  end

  task automatic wr(input logic [63:0] data, input bit accept);
    addr = 2'b10; d_in = data; nicEn = 1'b1; nicEnWR = 1'b1;
    if (accept) tx_q.push_back(data);
    @(negedge clk);
    nicEn = 1'b0; nicEnWR = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] exp, input string tag);
    addr = a; nicEn = 1'b1; nicEnWR = 1'b0;
    rd_q.push_back(exp);
    @(negedge clk);
    check(tag, d_out, rd_q.pop_front());
    nicEn = 1'b0;
  endtask

  task automatic send(input logic [63:0] data);
    net_si = 1'b1; net_di = data;
    @(negedge clk);
    net_si = 1'b0;
  endtask

  initial begin
    reset = 1'b0; addr = '0; d_in = '0; net_di = '0; nicEn = 1'b0; nicEnWR = 1'b0;
    net_si = 1'b0; net_ro = 1'b0; net_polarity = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_d_out", d_out, 64'd0);
    check("rst_net_so", {63'b0, net_so}, 64'd0);
    check("rst_net_do", net_do, 64'd0);
    check("rst_net_ri", {63'b0, net_ri}, 64'd1);
    reset = 1'b1;
    @(negedge clk);

    // Two queued words leave on consecutive cycles once the router is ready.
    net_polarity = 1'b1;
    wr(64'hA1, 1'b1);
    wr(64'hA2, 1'b1);
    check("b2b_idle_so", {63'b0, net_so}, 64'd0);
    net_ro = 1'b1;
    @(negedge clk);
    check("b2b_so_1", {63'b0, net_so}, 64'd1);
    @(negedge clk);
    check("b2b_so_2", {63'b0, net_so}, 64'd1);
    @(negedge clk);
    check("b2b_so_end", {63'b0, net_so}, 64'd0);
    rd(2'b11, 64'h0, "b2b_out_stat");

    // Wrong polarity holds the output FIFO full.
    net_polarity = 1'b0;
    for (int i = 1; i <= 4; i++) wr(64'hB0 + 64'(i), 1'b1);
    check("pol_hold_so", {63'b0, net_so}, 64'd0);
    rd(2'b11, 64'h11, "pol_out_stat_full");
    check("pol_hold_so2", {63'b0, net_so}, 64'd0);
    sent0 = n_sent;
    net_polarity = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pol_send_so", {63'b0, net_so}, 64'd1);
    end
    @(negedge clk);
    check("pol_send_end", {63'b0, net_so}, 64'd0);
    check("pol_send_count", 64'(n_sent - sent0), 64'd4);

    // Router fills the input FIFO; overflow attempt is ignored.
    net_ro = 1'b0;
    for (int i = 1; i <= 4; i++) send(64'(i));
    check("in_full_ri", {63'b0, net_ri}, 64'd0);
    send(64'h5);
    rd(2'b01, 64'h9, "in_stat_full");
    check("in_full_ri2", {63'b0, net_ri}, 64'd0);
    rd(2'b00, 64'h1, "in_data_1");
    check("in_ri_after_pop", {63'b0, net_ri}, 64'd1);
    rd(2'b00, 64'h2, "in_data_2");
    rd(2'b00, 64'h3, "in_data_3");
    rd(2'b00, 64'h4, "in_data_4");
    rd(2'b00, 64'h0, "in_data_empty");
    rd(2'b01, 64'h0, "in_stat_empty");

    // Fifth CPU write to a full output FIFO is dropped and flagged.
    for (int i = 1; i <= 4; i++) wr(64'hC0 + 64'(i), 1'b1);
    wr(64'hC5, 1'b0);
    rd(2'b11, 64'h13, "drop_stat_set");
    rd(2'b11, 64'h11, "drop_stat_clear");
    sent0 = n_sent;
    net_ro = 1'b1;
    repeat (7) @(negedge clk);
    check("drop_send_count", 64'(n_sent - sent0), 64'd4);
    check("drop_tx_q_left", 64'(tx_q.size()), 64'd0);
    rd(2'b11, 64'h0, "drop_stat_drained");

    // Read and router send on the same edge against a full, then non-full, input FIFO.
    net_ro = 1'b0;
    for (int i = 1; i <= 4; i++) send(64'hD0 + 64'(i));
    check("sim_full_ri", {63'b0, net_ri}, 64'd0);
    addr = 2'b00; nicEn = 1'b1; nicEnWR = 1'b0; net_si = 1'b1; net_di = 64'hD5;
    @(negedge clk);
    check("sim_full_rd", d_out, 64'hD1);
    check("sim_full_ri_next", {63'b0, net_ri}, 64'd1);
    nicEn = 1'b0; net_si = 1'b0;
    rd(2'b01, 64'h7, "sim_full_stat");
    addr = 2'b00; nicEn = 1'b1; nicEnWR = 1'b0; net_si = 1'b1; net_di = 64'hD6;
    @(negedge clk);
    check("sim_part_rd", d_out, 64'hD2);
    nicEn = 1'b0; net_si = 1'b0;
    rd(2'b01, 64'h7, "sim_part_stat");
    rd(2'b00, 64'hD3, "sim_drain_3");
    rd(2'b00, 64'hD4, "sim_drain_4");
    rd(2'b00, 64'hD6, "sim_drain_6");
    rd(2'b00, 64'h0, "sim_drain_empty");

    // Asynchronous reset mid-burst with two words on each side.
    wr(64'hE1, 1'b1);
    wr(64'hE2, 1'b1);
    send(64'hF1);
    send(64'hF2);
    addr = 2'b01; nicEn = 1'b1; nicEnWR = 1'b0; net_ro = 1'b1;
    @(posedge clk);
    #2;
    check("mid_pre_so", {63'b0, net_so}, 64'd1);
    check("mid_pre_d_out", d_out, 64'h5);
    reset = 1'b0;
    #1;
    check("mid_rst_so", {63'b0, net_so}, 64'd0);
    check("mid_rst_d_out", d_out, 64'd0);
    check("mid_rst_net_do", net_do, 64'd0);
    check("mid_rst_ri", {63'b0, net_ri}, 64'd1);
    tx_q.delete();
    nicEn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd(2'b01, 64'h0, "mid_in_stat");
    rd(2'b11, 64'h0, "mid_out_stat");
    repeat (3) @(negedge clk);
    check("mid_no_send", {63'b0, net_so}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
